// File: rtl/alu_result_stage.sv
// Execute/writeback boundary stage behind the 8-bit ALU: head + skid buffer, flag register, BNE resolve.
// Optional taken-branch counter output BrCount is enabled with `define ALU_RESULT_STAGE_PERF_EN.

package alu_defs_pkg;
  localparam logic [2:0] kADD  = 3'd0;
  localparam logic [2:0] kXOR  = 3'd1;
  localparam logic [2:0] kLSOR = 3'd2;
  localparam logic [2:0] kPAR  = 3'd3;
  localparam logic [2:0] kBNE  = 3'd4;
endpackage

module alu_result_stage
  import alu_defs_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Flush,
  input  logic          InValid,
  output logic          InReady,
  input  logic [2:0]    OP,
  input  logic [DW-1:0] AluOut,
  input  logic          AluZero,
  input  logic          AluParity,
  input  logic [AW-1:0] WrAddr,
  input  logic [DW-1:0] BrTarget,
  output logic          OutValid,
  input  logic          OutReady,
  output logic          RegWrEn,
  output logic [AW-1:0] RegWrAddr,
  output logic [DW-1:0] RegWrData,
  output logic          BrTaken,
  output logic [DW-1:0] BrPC,
  output logic          FlagZero,
  output logic          FlagParity
`ifdef ALU_RESULT_STAGE_PERF_EN
  ,
  output logic [7:0]    BrCount
`endif
);

  logic          head_valid;
  logic          head_wren;
  logic          head_br;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;
  logic [DW-1:0] head_pc;

  logic          skid_valid;
  logic          skid_wren;
  logic          skid_br;
  logic [AW-1:0] skid_addr;
  logic [DW-1:0] skid_data;
  logic [DW-1:0] skid_pc;

  logic          accept;
  logic          consume;
  logic          in_wren;
  logic          in_br;

  // An entry offered alongside Flush is discarded, so it never counts as accepted.
  always_comb begin
    accept  = InValid && InReady && !Flush;
    consume = head_valid && OutReady;
    in_wren = 1'b0;
    case (OP)
      kADD, kXOR, kLSOR, kPAR: in_wren = 1'b1;
      default:                 in_wren = 1'b0;
    endcase
    in_br = (OP == kBNE) && !AluZero;
  end

  // Head register: refilled from skid first so ordering is preserved, else from the new entry.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      head_valid <= 1'b0;
      head_wren  <= 1'b0;
      head_br    <= 1'b0;
      head_addr  <= '0;
      head_data  <= '0;
      head_pc    <= '0;
    end else if (Flush) begin
      head_valid <= 1'b0;
    end else if (!head_valid || consume) begin
      if (skid_valid) begin
        head_valid <= 1'b1;
        head_wren  <= skid_wren;
        head_br    <= skid_br;
        head_addr  <= skid_addr;
        head_data  <= skid_data;
        head_pc    <= skid_pc;
      end else if (accept) begin
        head_valid <= 1'b1;
        head_wren  <= in_wren;
        head_br    <= in_br;
        head_addr  <= WrAddr;
        head_data  <= AluOut;
        head_pc    <= BrTarget;
      end else begin
        head_valid <= 1'b0;
      end
    end
  end

  // Skid register only fills while the head is stalled; it empties whenever the head drains.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      skid_valid <= 1'b0;
      skid_wren  <= 1'b0;
      skid_br    <= 1'b0;
      skid_addr  <= '0;
      skid_data  <= '0;
      skid_pc    <= '0;
    end else if (Flush) begin
      skid_valid <= 1'b0;
    end else if (head_valid && !consume) begin
      if (accept) begin
        skid_valid <= 1'b1;
        skid_wren  <= in_wren;
        skid_br    <= in_br;
        skid_addr  <= WrAddr;
        skid_data  <= AluOut;
        skid_pc    <= BrTarget;
      end
    end else begin
      skid_valid <= 1'b0;
    end
  end

  // Architectural flags track accepted results immediately, regardless of downstream stalls.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      FlagZero   <= 1'b0;
      FlagParity <= 1'b0;
    end else if (accept) begin
      if (in_wren) begin
        FlagZero   <= AluZero;
        FlagParity <= AluParity;
      end else if (OP == kBNE) begin
        FlagZero   <= AluZero;
      end
    end
  end

  assign InReady   = ~skid_valid;
  assign OutValid  = head_valid;
  assign RegWrEn   = head_valid & head_wren;
  assign BrTaken   = head_valid & head_br;
  assign RegWrAddr = head_addr;
  assign RegWrData = head_data;
  assign BrPC      = head_pc;

`ifdef ALU_RESULT_STAGE_PERF_EN
  // Saturating count of taken branches handed downstream; survives Flush.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      BrCount <= 8'd0;
    end else if (consume && head_br && (BrCount != 8'hFF)) begin
      BrCount <= BrCount + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed steps plus random traffic against a 2-deep FIFO model.
// Define ALU_RESULT_STAGE_PERF_EN for both files to exercise BrCount.

module tb_alu_result_stage;
  import alu_defs_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Flush = 1'b0;
  logic       InValid = 1'b0;
  logic       InReady;
  logic [2:0] OP = 3'd0;
  logic [7:0] AluOut = 8'd0;
  logic       AluZero = 1'b0;
  logic       AluParity = 1'b0;
  logic [2:0] WrAddr = 3'd0;
  logic [7:0] BrTarget = 8'd0;
  logic       OutValid;
  logic       OutReady = 1'b0;
  logic       RegWrEn;
  logic [2:0] RegWrAddr;
  logic [7:0] RegWrData;
  logic       BrTaken;
  logic [7:0] BrPC;
  logic       FlagZero;
  logic       FlagParity;
`ifdef ALU_RESULT_STAGE_PERF_EN
  logic [7:0] BrCount;
`endif

  alu_result_stage #(.DW(8), .AW(3)) dut (
    .Clk(Clk), .Reset(Reset), .Flush(Flush),
    .InValid(InValid), .InReady(InReady),
    .OP(OP), .AluOut(AluOut), .AluZero(AluZero), .AluParity(AluParity),
    .WrAddr(WrAddr), .BrTarget(BrTarget),
    .OutValid(OutValid), .OutReady(OutReady),
    .RegWrEn(RegWrEn), .RegWrAddr(RegWrAddr), .RegWrData(RegWrData),
    .BrTaken(BrTaken), .BrPC(BrPC),
    .FlagZero(FlagZero), .FlagParity(FlagParity)
`ifdef ALU_RESULT_STAGE_PERF_EN
    , .BrCount(BrCount)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       wren;
    logic       br;
    logic [2:0] addr;
    logic [7:0] data;
    logic [7:0] pc;
  } ent_t;

  ent_t q[$];
  logic m_zero = 1'b0;
  logic m_par  = 1'b0;
  int   m_cnt  = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    ent_t h;
    h = '{wren: 1'b0, br: 1'b0, addr: 3'd0, data: 8'd0, pc: 8'd0};
    if (q.size() > 0) h = q[0];
    check("OutValid", OutValid, q.size() > 0);
    check("InReady", InReady, q.size() < 2);
    check("RegWrEn", RegWrEn, (q.size() > 0) && h.wren);
    check("BrTaken", BrTaken, (q.size() > 0) && h.br);
    check("FlagZero", FlagZero, m_zero);
    check("FlagParity", FlagParity, m_par);
    if (q.size() > 0) begin
      check("RegWrAddr", RegWrAddr, h.addr);
      check("RegWrData", RegWrData, h.data);
      check("BrPC", BrPC, h.pc);
    end
`ifdef ALU_RESULT_STAGE_PERF_EN
    check("BrCount", BrCount, m_cnt);
`endif
  endtask

  // One clock: drive inputs, advance the model from the spec rules, compare after the edge.
  task automatic applyStimulus(input logic inv, input logic [2:0] op, input logic [7:0] dat,
                               input logic z, input logic p, input logic [2:0] wa,
                               input logic [7:0] bt, input logic ordy, input logic fl);
    ent_t e;
    logic acc, con, wr;
    InValid = inv; OP = op; AluOut = dat; AluZero = z; AluParity = p;
    WrAddr = wa; BrTarget = bt; OutReady = ordy; Flush = fl;
    wr  = (op == kADD) || (op == kXOR) || (op == kLSOR) || (op == kPAR);
    e   = '{wren: wr, br: (op == kBNE) && !z, addr: wa, data: dat, pc: bt};
    acc = inv && (q.size() < 2) && !fl;
    con = (q.size() > 0) && ordy;
    @(posedge Clk);
    if (con && q[0].br && m_cnt < 255) m_cnt++;
    if (fl) q.delete();
    else begin
      if (con) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    if (acc && wr) begin m_zero = z; m_par = p; end
    else if (acc && op == kBNE) m_zero = z;
    #1;
    checkOutput();
  endtask

  task automatic idle(input logic ordy);
    applyStimulus(1'b0, kADD, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, ordy, 1'b0);
  endtask

  task automatic doReset();
    Reset = 1'b1; InValid = 1'b0; Flush = 1'b0; OutReady = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    q.delete(); m_zero = 1'b0; m_par = 1'b0; m_cnt = 0;
    Reset = 1'b0;
    checkOutput();
    check("rst_wraddr", RegWrAddr, 3'd0);
    check("rst_wrdata", RegWrData, 8'd0);
    check("rst_brpc", BrPC, 8'd0);
  endtask

  initial begin
    $display("[TB] start");
    doReset();

    // Back-to-back ADD then XOR with consumer ready.
    applyStimulus(1'b1, kADD, 8'h3C, 1'b0, 1'b0, 3'd2, 8'h11, 1'b1, 1'b0);
    check("add_en", RegWrEn, 1'b1);
    check("add_addr", RegWrAddr, 3'd2);
    check("add_data", RegWrData, 8'h3C);
    applyStimulus(1'b1, kXOR, 8'h00, 1'b1, 1'b0, 3'd5, 8'h22, 1'b1, 1'b0);
    check("xor_addr", RegWrAddr, 3'd5);
    check("xor_data", RegWrData, 8'h00);
    check("xor_zero", FlagZero, 1'b1);
    idle(1'b1);

    // Stall: three offers with consumer blocked, then drain in order.
    applyStimulus(1'b1, kADD,  8'hA1, 1'b0, 1'b1, 3'd1, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, kLSOR, 8'hB2, 1'b0, 1'b0, 3'd3, 8'h00, 1'b0, 1'b0);
    check("stall_rdy", InReady, 1'b0);
    applyStimulus(1'b1, kPAR,  8'hC3, 1'b0, 1'b1, 3'd4, 8'h00, 1'b0, 1'b0);
    check("stall_head", RegWrData, 8'hA1);
    applyStimulus(1'b0, kADD, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
    check("drain_1", RegWrData, 8'hB2);
    check("drain_rdy", InReady, 1'b1);
    idle(1'b1);
    check("drain_empty", OutValid, 1'b0);

    // BNE taken and not taken.
    applyStimulus(1'b1, kBNE, 8'h77, 1'b0, 1'b1, 3'd6, 8'h40, 1'b1, 1'b0);
    check("bne_taken", BrTaken, 1'b1);
    check("bne_pc", BrPC, 8'h40);
    check("bne_wren", RegWrEn, 1'b0);
    applyStimulus(1'b1, kBNE, 8'h00, 1'b1, 1'b0, 3'd6, 8'h50, 1'b1, 1'b0);
    check("bne_nt", BrTaken, 1'b0);
    idle(1'b1);

    // Flush with head and skid full and an LSOR offered.
    applyStimulus(1'b1, kADD, 8'h01, 1'b0, 1'b1, 3'd1, 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b1, kBNE, 8'h02, 1'b0, 1'b0, 3'd2, 8'h90, 1'b0, 1'b0);
    applyStimulus(1'b1, kLSOR, 8'h00, 1'b1, 1'b0, 3'd7, 8'h00, 1'b0, 1'b1);
    check("flush_ov", OutValid, 1'b0);
    check("flush_rdy", InReady, 1'b1);
    check("flush_wr", RegWrEn, 1'b0);
    check("flush_fz", FlagZero, 1'b0);
    check("flush_fp", FlagParity, 1'b1);
    idle(1'b1);

    // Random traffic against the FIFO model.
    for (int i = 0; i < 600; i++) begin
      logic fl;
      fl = ($urandom_range(0, 29) == 0);
      applyStimulus($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 8'($urandom),
                    1'($urandom), 1'($urandom), 3'($urandom), 8'($urandom),
                    fl ? 1'b0 : ($urandom_range(0, 9) < 6), fl);
    end

`ifdef ALU_RESULT_STAGE_PERF_EN
    doReset();
    for (int i = 0; i < 300; i++)
      applyStimulus(1'b1, kBNE, 8'h00, 1'b0, 1'b0, 3'd0, 8'(i), 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    check("brcnt_sat", BrCount, 8'd255);
    doReset();
    check("brcnt_rst", BrCount, 8'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: observed running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Execute/writeback boundary stage directly downstream of the 8-bit ALU.
- Captures the ALU result, Zero and Parity flags together with the opcode and destination register.
- Maintains the architectural flag register and resolves the BNE branch decision.
- Presents register-file write and branch requests through a valid/ready handshake, backed by a 2-entry skid buffer so the ALU can issue every cycle at full throughput.

Parameters:
- DW, 8, data width of ALU result and branch target.
- AW, 3, register-file address width (8 registers).

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Flush  input  1  drop all buffered entries (branch/redirect).
- InValid  input  1  ALU result valid this cycle.
- InReady  output  1  stage can accept an entry this cycle.
- OP  input  3  opcode; kBNE/kPAR/kADD/kXOR/kLSOR from definitions package.
- AluOut  input  DW  ALU result.
- AluZero  input  1  ALU Zero flag.
- AluParity  input  1  ALU Parity flag.
- WrAddr  input  AW  destination register.
- BrTarget  input  DW  branch target for kBNE.
- OutValid  output  1  entry available at head.
- OutReady  input  1  consumer accepts head entry.
- RegWrEn  output  1  head entry writes register file; gated with OutValid.
- RegWrAddr  output  AW  head write address.
- RegWrData  output  DW  head write data.
- BrTaken  output  1  head is kBNE with Zero==0; gated with OutValid.
- BrPC  output  DW  head branch target.
- FlagZero  output  1  architectural Zero flag.
- FlagParity  output  1  architectural Parity flag.

Behaviour:
- Reset values: both entries empty, OutValid=0, InReady=1, FlagZero=0, FlagParity=0, RegWrEn=0, BrTaken=0.
- Data outputs: RegWrAddr, RegWrData and BrPC reset to 0.
- Accept rule: an entry is accepted when InValid && InReady.
- Consume rule: an entry is consumed when OutValid && OutReady.
- Storage: head register plus one skid register.
- InReady is registered and equals "skid register empty".
- Latency: accepted entry appears at head the next cycle when head is empty or consumed that same cycle.
- Stall: if head is occupied and not consumed, the accepted entry goes to the skid register. InReady drops the following cycle.
- Drain: skid moves to head when head is consumed. InReady returns to 1 the next cycle.
- Simultaneous accept and consume:
  - Skid empty: new entry replaces head. No bubble, skid stays empty.
  - Skid full: InReady=0, so no accept is possible.
- Ordering: strictly in order; no entry is dropped or duplicated except by Flush/Reset.
- Write-enable decode, captured at accept time:
  - kADD, kXOR, kLSOR, kPAR: write enable 1.
  - kBNE and all other codes: write enable 0.
- Branch decode: BrTaken = (OP==kBNE) && !AluZero, captured at accept time.
- Flag update on accept, visible the next cycle, independent of downstream stall:
  - kADD/kXOR/kLSOR/kPAR: FlagZero<=AluZero, FlagParity<=AluParity.
  - kBNE: FlagZero<=AluZero only.
  - Other codes: flags hold.
- Flush:
  - Next cycle both entries are empty, OutValid=0, InReady=1.
  - An entry offered in the same cycle as Flush is discarded.
  - Flags are not reverted, and flag updates from the discarded entry are suppressed.
- Priority: Reset > Flush > normal operation.
- Reset or Flush mid-stall discards both entries with no write or branch emitted.
- Width: DW-bit data is passed through unmodified; no arithmetic in this block.

Optional Feature:
- Macro: ALU_RESULT_STAGE_PERF_EN.
- When defined, adds output BrCount (8 bits): count of consumed entries with BrTaken=1.
  - Saturates at 255.
  - Cleared by Reset; not cleared by Flush.
  - Increments the cycle after consume.
- When undefined: no port and no counter logic; all other behaviour is identical.

Test Plan:
- Reset held 2 cycles, then released -> OutValid=0, InReady=1, FlagZero=0, FlagParity=0.
- Back-to-back ADD (AluOut=0x3C, WrAddr=2) then XOR (AluOut=0x00, Zero=1, WrAddr=5), OutReady=1 -> head shows RegWrEn=1/addr 2/data 0x3C, then addr 5/data 0x00 on consecutive cycles. FlagZero=1 after the second.
- OutReady=0 with three consecutive InValid -> first two held (head+skid), InReady=0 on the 3rd cycle. Raising OutReady drains both in order, and InReady returns to 1.
- BNE with AluZero=0, BrTarget=0x40 -> BrTaken=1, BrPC=0x40, RegWrEn=0. BNE with AluZero=1 -> BrTaken=0.
- Flush asserted with head+skid full and an InValid LSOR offered -> next cycle OutValid=0, InReady=1, no write emitted, flags unchanged.
- With ALU_RESULT_STAGE_PERF_EN: 300 consumed taken BNEs -> BrCount=255. Reset -> 0.
